// File: rtl/keypad_entry_tx.sv
// Keypad transmit side: debounced enter/replay buttons drive {digit, enter} transactions
// to the lock, with a CODE_LEN-deep history of manual digits for replay.

module keypad_debounce #(
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw,
    output logic press
);
    localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);

    logic [1:0]    sync;
    logic          level;
    logic [DW-1:0] cnt;

    // Each sample that differs from the level advances the count, and any sample that
    // agrees restarts it. Only a 0->1 change of the level produces a press.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync  <= '0;
            level <= 1'b0;
            cnt   <= '0;
            press <= 1'b0;
        end else begin
            sync  <= {sync[0], raw};
            press <= 1'b0;
            if (sync[1] == level) begin
                cnt <= '0;
            end else if (cnt == DW'(DEBOUNCE_CYCLES - 1)) begin
                cnt   <= '0;
                level <= sync[1];
                press <= sync[1];
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end
endmodule

module keypad_entry_tx #(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int GAP_CYCLES      = 8,
    parameter int CODE_LEN        = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [3:0]                    sw_digit,
    input  logic                          btn_enter,
    input  logic                          btn_replay,
    output logic [3:0]                    digit,
    output logic                          enter,
    output logic                          busy,
    output logic [$clog2(CODE_LEN+1)-1:0] buf_count
);
    localparam int CW = $clog2(CODE_LEN + 1);
    localparam int PW = (CODE_LEN > 1) ? $clog2(CODE_LEN) : 1;
    localparam int GW = $clog2(GAP_CYCLES + 1);

    typedef enum logic [2:0] {S_IDLE, S_SETUP, S_STROBE, S_HOLD, S_GAP} state_t;

    state_t        state, state_nxt;
    logic [1:0]    btn_raw, press;
    logic          press_enter, press_replay;
    logic [3:0]    buf_mem [CODE_LEN];
    logic [PW-1:0] wr_ptr, base, rd_addr;
    logic [CW-1:0] rep_idx, idx_sel;
    logic [CW:0]   rd_sum;
    logic [GW-1:0] gap_cnt;
    logic          rep_mode, last_entry, gap_done;
    logic          start_man, start_rep, advance, push, enter_nxt, busy_nxt;

    assign btn_raw = {btn_replay, btn_enter};

    for (genvar i = 0; i < 2; i++) begin : g_db
        keypad_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db (
            .clk   (clk),
            .rst_n (rst_n),
            .raw   (btn_raw[i]),
            .press (press[i])
        );
    end

    assign press_enter  = press[0];
    assign press_replay = press[1];
    assign last_entry   = (rep_idx == CW'(buf_count - 1'b1));
    assign gap_done     = (gap_cnt == GW'(GAP_CYCLES - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:   if (press_enter || (press_replay && buf_count != '0)) state_nxt = S_SETUP;
            S_SETUP:  state_nxt = S_STROBE;
            S_STROBE: state_nxt = S_HOLD;
            S_HOLD:   state_nxt = (!rep_mode || last_entry) ? S_IDLE : S_GAP;
            S_GAP:    if (gap_done) state_nxt = S_SETUP;
            default:  state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        start_man = (state == S_IDLE) && press_enter;
        start_rep = (state == S_IDLE) && !press_enter && press_replay && (buf_count != '0);
        advance   = (state == S_GAP) && gap_done;
        push      = (state == S_STROBE) && !rep_mode;
        enter_nxt = (state_nxt == S_STROBE);
        busy_nxt  = (state_nxt != S_IDLE);
        // Once the buffer has wrapped, the oldest entry sits at the write pointer.
        base      = (buf_count == CW'(CODE_LEN)) ? wr_ptr : '0;
        idx_sel   = start_rep ? '0 : rep_idx + 1'b1;
        rd_sum    = (CW+1)'(base) + (CW+1)'(idx_sel);
        rd_addr   = (rd_sum >= (CW+1)'(CODE_LEN)) ? PW'(rd_sum - (CW+1)'(CODE_LEN)) : PW'(rd_sum);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            digit     <= '0;
            enter     <= 1'b0;
            busy      <= 1'b0;
            buf_count <= '0;
            wr_ptr    <= '0;
            rep_mode  <= 1'b0;
            rep_idx   <= '0;
            gap_cnt   <= '0;
            for (int i = 0; i < CODE_LEN; i++) buf_mem[i] <= '0;
        end else begin
            enter <= enter_nxt;
            busy  <= busy_nxt;
            if (start_man) begin
                digit    <= sw_digit;
                rep_mode <= 1'b0;
            end else if (start_rep) begin
                digit    <= buf_mem[rd_addr];
                rep_mode <= 1'b1;
                rep_idx  <= '0;
            end else if (advance) begin
                digit   <= buf_mem[rd_addr];
                rep_idx <= rep_idx + 1'b1;
            end
            gap_cnt <= (state == S_GAP && !gap_done) ? gap_cnt + 1'b1 : '0;
            if (push) begin
                buf_mem[wr_ptr] <= digit;
                wr_ptr          <= (wr_ptr == PW'(CODE_LEN - 1)) ? '0 : wr_ptr + 1'b1;
                if (buf_count != CW'(CODE_LEN)) buf_count <= buf_count + 1'b1;
            end
        end
    end
endmodule
